mapped_mem_bridge: RTL and testbench
====================================

# mapped_mem_bridge

Downstream stage of the memory mapper: joins the mapper's 12-bit page output with the CPU's low 12 address bits into a 24-bit physical address and runs the access on the external memory port. A single-entry posted write buffer hides write latency. Reads stall the CPU through a valid/ready handshake, and a per-transaction timeout keeps a dead memory port from hanging the CPU. Sits between the 6502 bus decode/memory mapper and the SDRAM/SRAM controller.

## Interface
- TIMEOUT, default 255: cycles to wait for mem_ack before a transaction is aborted. Range 1–65535.
- clk  in  1  system clock
- rst  in  1  reset. Synchronous, active-high.
- cpu_valid  in  1  CPU access request to mapped memory. Accepted on an edge where cpu_valid & cpu_rdy.
- cpu_rw  in  1  1 = read, 0 = write
- cpu_addr_lo  in  12  CPU A[11:0]
- mo  in  12  mapper output; becomes physical address [23:12]
- cpu_wdata  in  8  write data
- cpu_rdy  out  1  bridge can accept a request (combinational, see Operation)
- cpu_rvalid  out  1  one-cycle pulse; cpu_rdata valid
- cpu_rdata  out  8  read data
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  24  physical address {mo, cpu_addr_lo}
- mem_wdata  out  8  write data
- mem_ack  in  1  memory completion. Read data is valid on mem_rdata in the same cycle.
- mem_rdata  in  8  read data
- err  out  1  sticky timeout flag. Cleared only by rst.

## Operation
- **Physical address:** pa = {mo, cpu_addr_lo}, captured at acceptance. Later changes to mo do not affect accepted requests.
- **Write buffer:** registers wb_valid, wb_addr[23:0], wb_data[8].
  - An accepted write loads the buffer; the CPU is never stalled for an accepted write.
  - The buffer is issued to memory when the port is idle.
  - wb_valid clears on the edge where mem_ack is sampled for that write.
- **cpu_rdy:** = (state == IDLE) & ~(~cpu_rw & wb_valid).
  - Writes stall while the buffer is occupied.
  - Reads are accepted whenever IDLE.
- **Read hit:** accepted read with wb_valid and pa == wb_addr returns wb_data.
  - cpu_rvalid pulses the next cycle; no memory read is issued.
- **Read miss:** pa is stored in rd_addr.
  - If wb_valid, the write drains first (DRAIN), then the read issues (RD).
  - Otherwise the read issues immediately.
- **States:**
  - IDLE. Go to RD on a read miss with wb empty. Go to DRAIN on a read miss with wb_valid. Stay in IDLE on a hit or a write.
  - DRAIN → RD when the write completes (ack or timeout).
  - RD → RESP on ack or timeout.
  - RESP: drive cpu_rvalid = 1 for one cycle, then → IDLE.
- **Memory port:**
  - mem_req, mem_we, mem_addr and mem_wdata are registered and held stable while mem_req = 1.
  - A transaction completes on the edge where mem_req & mem_ack.
  - mem_req is low for at least one cycle between transactions.
  - Priority when idle: write buffer before a pending read.
  - In IDLE with wb_valid and no read pending, the buffered write issues on its own.
- **Timeout:**
  - A 16-bit counter clears when mem_req rises and increments each cycle mem_req & ~mem_ack.
  - Reaching TIMEOUT aborts the transaction: mem_req drops next cycle and err is set.
  - Timed-out write: buffer discarded.
  - Timed-out read: RESP returns 8'hFF.
- **Late ack:** mem_ack while mem_req = 0 is ignored.

## Timing
- **Reset values:** cpu_rvalid 0, cpu_rdata 8'h00, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, err 0, wb_valid 0, state IDLE.
  - cpu_rdy = 1 in the first cycle after reset.
- **Reset mid-operation:** the outstanding read and the buffered write are dropped. mem_req is 0 after the reset edge. No cpu_rvalid is issued for dropped reads.
- **Write latency:** mem_req rises 1 cycle after acceptance (buffer empty, port idle).
- **Read hit latency:** cpu_rvalid 1 cycle after acceptance.
- **Read miss latency, buffer empty:**
  - mem_req rises in cycle A+1.
  - If ack arrives in cycle A+1+k, cpu_rvalid is high in cycle A+2+k.
  - With k = 0, rvalid is at A+2.
- **Read miss behind a pending write:** the write completes, mem_req is low for 1 cycle, then the read issues.
- **Simultaneous events:**
  - A write accepted in the same cycle the buffer's ack arrives is not possible, because cpu_rdy = 0 then.
  - A write is accepted the cycle after wb_valid clears.

## Structure
- **Shared package `super6502_pkg`:**
  - state enum (IDLE, DRAIN, RD, RESP)
  - PA_W = 24, PAGE_W = 12, OFF_W = 12
  - RD_TIMEOUT_DATA = 8'hFF
- **Sub-module `mem_port_timer`:** the timeout counter (inputs req and ack; output expired). It is reused by other bus bridges.
- Write buffer, FSM and forwarding compare stay in the top module.

## Test plan
- **Posted write:** write 8'h5A with mo = 12'h003, addr_lo = 12'h456, mem_ack after 3 cycles.
  - mem_addr = 24'h003456, mem_we = 1, mem_wdata = 8'h5A.
  - cpu_rdy stays 1 for the accepting cycle; the next write stalls until the ack.
- **Read miss:** mo = 12'h010, addr_lo = 12'h001, mem_rdata = 8'hC3 with zero-wait ack.
  - mem_addr = 24'h010001, mem_we = 0.
  - cpu_rvalid at acceptance +2 with cpu_rdata = 8'hC3.
- **Forwarding:** write 8'h77 to 24'h000100 while mem_ack is held low, then read the same pa.
  - cpu_rvalid next cycle with 8'h77; no read on the memory port.
- **Drain ordering:** buffered write to 24'h000200, then a read of 24'h000300.
  - The write transaction completes first, mem_req is low for 1 cycle, then the read issues.
- **Timeout:** TIMEOUT = 4, read with mem_ack tied low.
  - mem_req drops after 4 cycles, err = 1, cpu_rdata = 8'hFF, cpu_rvalid pulses once.
- **Reset mid-read:** assert rst while in RD.
  - mem_req = 0 next cycle, no cpu_rvalid, cpu_rdy = 1, err = 0.

Source files
------------

// File: rtl/super6502_pkg.sv
// Shared types and widths for the super6502 bus bridges.
package super6502_pkg;
  localparam int PA_W   = 24;
  localparam int PAGE_W = 12;
  localparam int OFF_W  = 12;
  localparam int DATA_W = 8;

  localparam logic [DATA_W-1:0] RD_TIMEOUT_DATA = 8'hFF;

  typedef enum logic [1:0] {IDLE, DRAIN, RD, RESP} state_t;

  function automatic logic [PA_W-1:0] make_pa(input logic [PAGE_W-1:0] page,
                                              input logic [OFF_W-1:0]  off);
    return {page, off};
  endfunction
endpackage

// File: rtl/mapped_mem_bridge_if.sv
// CPU-side request bus and external memory port of the mapped memory bridge.
interface cpu_bus_if;
  import super6502_pkg::*;
  logic              cpu_valid;
  logic              cpu_rw;
  logic [OFF_W-1:0]  cpu_addr_lo;
  logic [PAGE_W-1:0] mo;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_rdy;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  modport master (output cpu_valid, cpu_rw, cpu_addr_lo, mo, cpu_wdata,
                  input  cpu_rdy, cpu_rvalid, cpu_rdata);
  modport slave  (input  cpu_valid, cpu_rw, cpu_addr_lo, mo, cpu_wdata,
                  output cpu_rdy, cpu_rvalid, cpu_rdata);
endinterface

interface mem_bus_if;
  import super6502_pkg::*;
  logic              mem_req;
  logic              mem_we;
  logic [PA_W-1:0]   mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_port_timer.sv
// Per-transaction ack timeout: flags expiry on the TIMEOUT-th unacked cycle of a request.
module mem_port_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_ack,
  output logic o_expired
);
  logic [15:0] r_cnt;

  // Held at zero while idle, so every new request starts counting from zero.
  always_ff @(posedge clk) begin
    if (rst || !i_req) r_cnt <= '0;
    else if (!i_ack)   r_cnt <= r_cnt + 16'd1;
  end

  assign o_expired = i_req & ~i_ack & (r_cnt == 16'(TIMEOUT - 1));
endmodule

// File: rtl/mapped_mem_bridge.sv
// Joins mapper page + CPU offset into a physical address and runs the access
// on the memory port, with a one-entry posted write buffer and ack timeout.
module mapped_mem_bridge
  import super6502_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic      clk,
  input  logic      rst,
  cpu_bus_if.slave  cpu,
  mem_bus_if.master mem,
  output logic      err
);
  state_t            r_state, w_next;
  logic              r_wb_valid;
  logic [PA_W-1:0]   r_wb_addr, r_rd_addr, r_mem_addr;
  logic [DATA_W-1:0] r_wb_data, r_mem_wdata, r_rdata;
  logic              r_mem_req, r_mem_we, r_rvalid, r_err;

  logic              w_rdy, w_accept, w_acc_wr, w_acc_rd, w_hit, w_miss;
  logic              w_expired, w_done, w_tout, w_wb_done;
  logic              w_issue_wb, w_issue_new, w_issue_rd, w_rd_done;
  logic [PA_W-1:0]   w_pa, w_rd_issue_addr;

  assign w_pa     = make_pa(cpu.mo, cpu.cpu_addr_lo);
  assign w_rdy    = (r_state == IDLE) & ~(~cpu.cpu_rw & r_wb_valid);
  assign w_accept = cpu.cpu_valid & w_rdy;
  assign w_acc_wr = w_accept & ~cpu.cpu_rw;
  assign w_acc_rd = w_accept & cpu.cpu_rw;
  assign w_hit    = w_acc_rd & r_wb_valid & (w_pa == r_wb_addr);
  assign w_miss   = w_acc_rd & ~w_hit;

  mem_port_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_req     (r_mem_req),
    .i_ack     (mem.mem_ack),
    .o_expired (w_expired)
  );

  // Acks seen while no request is outstanding never complete anything.
  assign w_done      = r_mem_req & (mem.mem_ack | w_expired);
  assign w_tout      = r_mem_req & w_expired;
  assign w_wb_done   = w_done & r_mem_we;
  assign w_issue_new = w_acc_wr & ~r_mem_req;
  assign w_rd_issue_addr = (r_state == IDLE) ? w_pa : r_rd_addr;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_issue_wb = 1'b0;
    w_issue_rd = 1'b0;
    w_rd_done  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_issue_wb = r_wb_valid & ~r_mem_req;
        if (w_miss) begin
          // A write finishing on this very edge leaves nothing to drain.
          if (r_wb_valid && !w_wb_done) w_next = DRAIN;
          else begin
            w_next     = RD;
            w_issue_rd = ~r_wb_valid;
          end
        end
      end
      DRAIN: begin
        w_issue_wb = r_wb_valid & ~r_mem_req;
        if (w_wb_done || !r_wb_valid) w_next = RD;
      end
      RD: begin
        if (!r_mem_req) w_issue_rd = 1'b1;
        else if (w_done) begin
          w_rd_done = 1'b1;
          w_next    = RESP;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_valid  <= 1'b0;
      r_wb_addr   <= '0;
      r_wb_data   <= '0;
      r_rd_addr   <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_rvalid <= w_hit | w_rd_done;
      if (w_hit)     r_rdata <= r_wb_data;
      if (w_rd_done) r_rdata <= mem.mem_ack ? mem.mem_rdata : RD_TIMEOUT_DATA;
      if (w_miss)    r_rd_addr <= w_pa;
      if (w_tout)    r_err <= 1'b1;

      // Completion (ack or timeout) retires the buffered write either way.
      if (w_wb_done) r_wb_valid <= 1'b0;
      if (w_acc_wr) begin
        r_wb_valid <= 1'b1;
        r_wb_addr  <= w_pa;
        r_wb_data  <= cpu.cpu_wdata;
      end

      if (w_done) r_mem_req <= 1'b0;
      else if (w_issue_wb) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= 1'b1;
        r_mem_addr  <= r_wb_addr;
        r_mem_wdata <= r_wb_data;
      end else if (w_issue_new) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= 1'b1;
        r_mem_addr  <= w_pa;
        r_mem_wdata <= cpu.cpu_wdata;
      end else if (w_issue_rd) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= 1'b0;
        r_mem_addr  <= w_rd_issue_addr;
      end
    end
  end

  assign cpu.cpu_rdy    = w_rdy;
  assign cpu.cpu_rvalid = r_rvalid;
  assign cpu.cpu_rdata  = r_rdata;
  assign mem.mem_req    = r_mem_req;
  assign mem.mem_we     = r_mem_we;
  assign mem.mem_addr   = r_mem_addr;
  assign mem.mem_wdata  = r_mem_wdata;
  assign err            = r_err;
endmodule

// File: tb/tb_mapped_mem_bridge.sv
// Directed scoreboard bench for mapped_mem_bridge (TIMEOUT = 4).
module tb_mapped_mem_bridge;
  logic clk = 1'b0;
  logic rst;
  logic err;
  always #5 clk = ~clk;

  cpu_bus_if cpu();
  mem_bus_if mem();

  mapped_mem_bridge #(.TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .cpu (cpu),
    .mem (mem),
    .err (err)
  );

  typedef struct { logic [23:0] addr; logic we; logic [7:0] data; } mtx_t;
  mtx_t       exp_mem[$];
  logic [7:0] exp_rd[$];
  mtx_t       em;
  logic [7:0] er;

  int  checks = 0, errors = 0;
  int  ack_lat = 0, wcnt = 0;
  logic [7:0] rd_val = 8'h00;
  logic prev_req = 1'b0;
  time rise_t = 0, fall_t = 0, gap_t = 0, hi_t = 0, rv_t = 0, acc_t = 0, t1 = 0;
  int  rise_cnt = 0, rv_cnt = 0, base = 0, rc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Memory model: ack after ack_lat wait cycles (-1 = never), one-cycle ack pulse.
  initial begin
    mem.mem_ack = 1'b0;
    mem.mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (mem.mem_ack) begin
        mem.mem_ack = 1'b0;
        wcnt = 0;
      end else if (mem.mem_req === 1'b1) begin
        if (ack_lat >= 0 && wcnt == ack_lat) begin
          mem.mem_ack = 1'b1;
          mem.mem_rdata = rd_val;
        end else wcnt++;
      end else wcnt = 0;
    end
  end

  // Monitor: pops expected memory transactions and read responses as they appear.
  initial begin
    forever begin
      @(negedge clk);
      if (mem.mem_req === 1'b1 && !prev_req) begin
        gap_t = $time - fall_t;
        rise_t = $time;
        rise_cnt++;
        if (exp_mem.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_mem_txn: addr %0h we %0b, none expected", mem.mem_addr, mem.mem_we);
        end else begin
          em = exp_mem.pop_front();
          check("mem_addr", mem.mem_addr, em.addr);
          check("mem_we", mem.mem_we, em.we);
          if (em.we) check("mem_wdata", mem.mem_wdata, em.data);
        end
      end
      if (mem.mem_req !== 1'b1 && prev_req) begin
        fall_t = $time;
        hi_t = $time - rise_t;
      end
      prev_req = (mem.mem_req === 1'b1);
      if (cpu.cpu_rvalid === 1'b1) begin
        rv_t = $time;
        rv_cnt++;
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rvalid: rdata %0h, none expected", cpu.cpu_rdata);
        end else begin
          er = exp_rd.pop_front();
          check("cpu_rdata", cpu.cpu_rdata, er);
        end
      end
    end
  end

  task automatic issue(input logic rw, input logic [11:0] page, input logic [11:0] lo,
                       input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    cpu.cpu_valid = 1'b1; cpu.cpu_rw = rw; cpu.mo = page;
    cpu.cpu_addr_lo = lo; cpu.cpu_wdata = d;
    #1;
    while (cpu.cpu_rdy !== 1'b1 && n < 100) begin
      @(negedge clk); #1; n++;
    end
    check("accept_wait", 64'(n < 100), 1);
    @(posedge clk);
    acc_t = $time;
    #1;
    cpu.cpu_valid = 1'b0;
    cpu.mo = 12'hFFF;
  endtask

  task automatic wait_rv(input int target);
    int n = 0;
    while (rv_cnt < target && n < 100) begin
      @(negedge clk); n++;
    end
    @(negedge clk); #1;
    check("rvalid_arrived", 64'(rv_cnt >= target), 1);
  endtask

  task automatic wait_quiet();
    int n = 0;
    while ((exp_mem.size() != 0 || exp_rd.size() != 0 || mem.mem_req === 1'b1) && n < 100) begin
      @(negedge clk); n++;
    end
    check("port_quiet", 64'(n < 100), 1);
    repeat (2) @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    cpu.cpu_valid = 1'b0; cpu.cpu_rw = 1'b0; cpu.mo = '0;
    cpu.cpu_addr_lo = '0; cpu.cpu_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_cpu_rdy", cpu.cpu_rdy, 1);
    check("rst_rvalid", cpu.cpu_rvalid, 0);
    check("rst_rdata", cpu.cpu_rdata, 0);
    check("rst_mem_req", mem.mem_req, 0);
    check("rst_mem_we", mem.mem_we, 0);
    check("rst_mem_addr", mem.mem_addr, 0);
    check("rst_mem_wdata", mem.mem_wdata, 0);
    check("rst_err", err, 0);

    // Posted write, second write stalls until the first one's ack.
    ack_lat = 3;
    exp_mem.push_back('{24'h003456, 1'b1, 8'h5A});
    issue(1'b0, 12'h003, 12'h456, 8'h5A);
    t1 = acc_t;
    @(negedge clk); #1;
    check("wr_req_latency", rise_t - t1, 5);
    cpu.cpu_valid = 1'b1; cpu.cpu_rw = 1'b0; cpu.mo = 12'h003;
    cpu.cpu_addr_lo = 12'h457; cpu.cpu_wdata = 8'h11;
    #1;
    check("wr_stall_rdy", cpu.cpu_rdy, 0);
    exp_mem.push_back('{24'h003457, 1'b1, 8'h11});
    issue(1'b0, 12'h003, 12'h457, 8'h11);
    check("wr_stall_cycles", acc_t - t1, 50);
    wait_quiet();

    // Read miss with zero-wait ack.
    ack_lat = 0; rd_val = 8'hC3;
    exp_mem.push_back('{24'h010001, 1'b0, 8'h00});
    exp_rd.push_back(8'hC3);
    base = rv_cnt;
    issue(1'b1, 12'h010, 12'h001, 8'h00);
    t1 = acc_t;
    wait_rv(base + 1);
    check("miss_req_latency", rise_t - t1, 5);
    check("miss_rvalid_latency", rv_t - t1, 15);
    wait_quiet();

    // Forwarding from the write buffer while the write is still unacked.
    ack_lat = 3;
    rc = rise_cnt;
    exp_mem.push_back('{24'h000100, 1'b1, 8'h77});
    issue(1'b0, 12'h000, 12'h100, 8'h77);
    exp_rd.push_back(8'h77);
    base = rv_cnt;
    issue(1'b1, 12'h000, 12'h100, 8'h00);
    t1 = acc_t;
    wait_rv(base + 1);
    check("hit_rvalid_latency", rv_t - t1, 5);
    wait_quiet();
    check("hit_mem_txn_count", 64'(rise_cnt - rc), 1);

    // Read miss behind a buffered write: write first, one idle cycle, then read.
    ack_lat = 2; rd_val = 8'h9E;
    exp_mem.push_back('{24'h000200, 1'b1, 8'hAB});
    issue(1'b0, 12'h000, 12'h200, 8'hAB);
    exp_mem.push_back('{24'h000300, 1'b0, 8'h00});
    exp_rd.push_back(8'h9E);
    base = rv_cnt;
    issue(1'b1, 12'h000, 12'h300, 8'h00);
    wait_rv(base + 1);
    check("drain_req_gap", gap_t, 10);
    wait_quiet();
    check("err_before_timeout", err, 0);

    // Timeout on a read.
    ack_lat = -1;
    exp_mem.push_back('{24'h020005, 1'b0, 8'h00});
    exp_rd.push_back(8'hFF);
    base = rv_cnt;
    issue(1'b1, 12'h020, 12'h005, 8'h00);
    wait_rv(base + 1);
    check("timeout_req_time", hi_t, 40);
    check("timeout_err", err, 1);
    repeat (5) @(negedge clk);
    #1;
    check("timeout_rvalid_count", 64'(rv_cnt - base), 1);
    wait_quiet();

    // Reset while a read is outstanding.
    exp_mem.push_back('{24'h030000, 1'b0, 8'h00});
    base = rv_cnt;
    issue(1'b1, 12'h030, 12'h000, 8'h00);
    @(negedge clk);
    @(negedge clk); #1;
    check("rd_outstanding", mem.mem_req, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstmid_mem_req", mem.mem_req, 0);
    check("rstmid_err", err, 0);
    check("rstmid_cpu_rdy", cpu.cpu_rdy, 1);
    check("rstmid_rvalid", cpu.cpu_rvalid, 0);
    repeat (8) @(negedge clk);
    #1;
    check("rstmid_no_rvalid", 64'(rv_cnt - base), 0);

    check("exp_mem_empty", 64'(exp_mem.size()), 0);
    check("exp_rd_empty", 64'(exp_rd.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
endmodule
